// File: rtl/stream_sched.sv
// stream_sched: two-requester packet scheduler feeding a stream generator.
//
// Ports
//   clk, rst_n                      clock, asynchronous active-low reset
//   req0/req1, len0/len1            packet pending and its byte count (len sampled at grant)
//   dat0/dat1, vld0/vld1, rdy0/rdy1 per-requester byte handshake (rdy only for the granted side)
//   gnt[1:0], done[1:0]             one-hot grant, one-cycle completion pulse
//   busy, err                       packet in progress, sticky watchdog error
//   sg_din, sg_push, sg_op_en       stream generator write data, push and operate enable
//   sg_full, sg_empty               stream generator status
//   sg_tvalid, sg_tlast, sg_tready  generator output stream handshake as seen at the sink
//
// Build option: define STREAM_SCHED_WDOG_EN to add a 255-cycle DRAIN watchdog
// that sets a sticky err and forces completion; otherwise err is tied low.
//
// state  | meaning
// IDLE   | no packet; round-robin arbitration on req0/req1
// LOAD   | push granted requester's bytes into the generator
// SETTLE | one quiet cycle so generator count/empty registers update
// DRAIN  | op_en high until the sink takes the tlast beat
// DONE   | one-cycle done pulse, record last-served requester

module stream_sched (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       req0,
   input  logic       req1,
   input  logic [3:0] len0,
   input  logic [3:0] len1,
   input  logic [7:0] dat0,
   input  logic [7:0] dat1,
   input  logic       vld0,
   input  logic       vld1,
   output logic       rdy0,
   output logic       rdy1,
   output logic [1:0] gnt,
   output logic [1:0] done,
   output logic       busy,
   output logic       err,
   output logic [7:0] sg_din,
   output logic       sg_push,
   output logic       sg_op_en,
   input  logic       sg_full,
   input  logic       sg_empty,
   input  logic       sg_tvalid,
   input  logic       sg_tlast,
   input  logic       sg_tready
);

   typedef enum logic [2:0] {IDLE, LOAD, SETTLE, DRAIN, DONE} state_t;

   state_t     state, state_nx;
   logic       sel, sel_nx;      // granted requester: 0 -> req0, 1 -> req1
   logic       last, last_nx;    // last-served requester
   logic [3:0] rem, rem_nx;
   logic       pick;
   logic [3:0] len_pick;
   logic       push;
   logic [1:0] gnt_oh;
   logic       drain_exit;
   logic       unused_sg_empty;

   assign unused_sg_empty = sg_empty;
   assign drain_exit      = sg_tvalid & sg_tlast & sg_tready;
   assign gnt_oh          = sel ? 2'b10 : 2'b01;
   // On a tie the requester not served last wins.
   assign pick            = (req0 & req1) ? ~last : req1;
   assign len_pick        = pick ? len1 : len0;
   assign push            = (sel ? vld1 : vld0) & ~sg_full;

`ifdef STREAM_SCHED_WDOG_EN
   logic [7:0] wd, wd_nx;
   logic       err_q, err_nx;
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         sel   <= 1'b0;
         last  <= 1'b1;
         rem   <= 4'd0;
`ifdef STREAM_SCHED_WDOG_EN
         wd    <= 8'd0;
         err_q <= 1'b0;
`endif
      end else begin
         state <= state_nx;
         sel   <= sel_nx;
         last  <= last_nx;
         rem   <= rem_nx;
`ifdef STREAM_SCHED_WDOG_EN
         wd    <= wd_nx;
         err_q <= err_nx;
`endif
      end
   end

   always_comb begin
      state_nx = state;
      sel_nx   = sel;
      last_nx  = last;
      rem_nx   = rem;
`ifdef STREAM_SCHED_WDOG_EN
      wd_nx    = wd;
      err_nx   = err_q;
`endif
      gnt      = 2'b00;
      done     = 2'b00;
      busy     = 1'b0;
      rdy0     = 1'b0;
      rdy1     = 1'b0;
      sg_push  = 1'b0;
      sg_op_en = 1'b0;
      sg_din   = 8'h00;

      case (state)
         IDLE: begin
            if (req0 | req1) begin
               sel_nx   = pick;
               rem_nx   = len_pick;
               state_nx = (len_pick == 4'd0) ? DONE : LOAD;
            end
         end
         LOAD: begin
            gnt     = gnt_oh;
            busy    = 1'b1;
            sg_push = push;
            rdy0    = push & ~sel;
            rdy1    = push & sel;
            sg_din  = sel ? dat1 : dat0;
            if (push) begin
               rem_nx = rem - 4'd1;
               if (rem == 4'd1) state_nx = SETTLE;
            end
         end
         SETTLE: begin
            gnt      = gnt_oh;
            busy     = 1'b1;
            state_nx = DRAIN;
`ifdef STREAM_SCHED_WDOG_EN
            // Down-counter terminal count at 0 gives 255 DRAIN cycles.
            wd_nx    = 8'd254;
`endif
         end
         DRAIN: begin
            gnt      = gnt_oh;
            busy     = 1'b1;
            sg_op_en = 1'b1;
            if (drain_exit) begin
               state_nx = DONE;
            end
`ifdef STREAM_SCHED_WDOG_EN
            else if (wd == 8'd0) begin
               err_nx   = 1'b1;
               state_nx = DONE;
            end else begin
               wd_nx = wd - 8'd1;
            end
`endif
         end
         DONE: begin
            gnt      = gnt_oh;
            done     = gnt_oh;
            last_nx  = sel;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

endmodule
